// File: rtl/char_pool.sv
// char_pool: fixed pool of falling characters; each frame moves every occupied slot, then may spawn one.
// Build macro CHAR_POOL_CLAMP_X_EN clamps a spawned horizontal position of 640 or more to 639.
module char_pool #(
    parameter int SLOTS     = 8,
    parameter int SCREEN_H  = 480,
    parameter int SPAWN_DIV = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [22:0]              newCh,
    input  logic                     kill_valid,
    input  logic [$clog2(SLOTS)-1:0] kill_idx,
    input  logic [$clog2(SLOTS)-1:0] rd_idx,
    output logic [22:0]              rd_entry,
    output logic [SLOTS-1:0]         active_mask,
    output logic                     busy,
    output logic                     miss_pulse,
    output logic [7:0]               miss_count,
    output logic [7:0]               drop_count
);
    // state | meaning
    // IDLE  | waiting for frame_tick
    // MOVE  | advancing slot visit_idx, one slot per cycle
    // SPAWN | spawn attempt into the lowest free slot when the frame divider expires
    localparam int            IW    = $clog2(SLOTS);
    localparam logic [9:0]    LIMIT = 10'(SCREEN_H);
    localparam logic [7:0]    DIV   = 8'(SPAWN_DIV);
    localparam logic [IW-1:0] LAST  = IW'(SLOTS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

    state_t           state;
    logic [IW-1:0]    visit_idx;
    logic [7:0]       frame_cnt;
    logic [22:0]      slot_q [SLOTS];
    logic [SLOTS-1:0] active_q;

    logic [22:0]   cur;
    logic [3:0]    step;
    logic [9:0]    sum;
    logic          exits;
    logic          kill_hit;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [9:0]    spawn_x;
    logic          unused_vert;

    assign unused_vert = ^newCh[18:10];

    always_comb begin
        cur      = slot_q[visit_idx];
        step     = (cur[22:19] == 4'd0) ? 4'd1 : cur[22:19];
        sum      = {1'b0, cur[18:10]} + {6'd0, step};
        exits    = (sum >= LIMIT);
        kill_hit = kill_valid && (kill_idx == visit_idx);
    end

    // Scan downward so the last hit is the lowest free index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
`ifdef CHAR_POOL_CLAMP_X_EN
        spawn_x = (newCh[9:0] >= 10'd640) ? 10'd639 : newCh[9:0];
`else
        spawn_x = newCh[9:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            visit_idx  <= '0;
            frame_cnt  <= 8'd0;
            active_q   <= '0;
            miss_pulse <= 1'b0;
            miss_count <= 8'd0;
            drop_count <= 8'd0;
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
        end else begin
            miss_pulse <= 1'b0;
            // A later assignment below (spawn load) overrides this kill.
            if (kill_valid) active_q[kill_idx] <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state     <= MOVE;
                        busy      <= 1'b1;
                        visit_idx <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                MOVE: begin
                    if (active_q[visit_idx] && !kill_hit) begin
                        if (exits) begin
                            active_q[visit_idx] <= 1'b0;
                            miss_pulse          <= 1'b1;
                            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                        end else begin
                            slot_q[visit_idx][18:10] <= sum[8:0];
                        end
                    end
                    visit_idx <= visit_idx + IW'(1);
                    if (visit_idx == LAST) state <= SPAWN;
                end
                SPAWN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (frame_cnt == DIV) begin
                        frame_cnt <= 8'd0;
                        if (free_found) begin
                            slot_q[free_idx]   <= {newCh[22:19], 9'd0, spawn_x};
                            active_q[free_idx] <= 1'b1;
                        end else if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_entry    = slot_q[rd_idx];
    assign active_mask = active_q;
endmodule

// File: tb/tb_char_pool.sv
// Directed bench for char_pool: frame-level reference model feeds a scoreboard of expected outcomes.
module tb_char_pool;
    logic        clk = 1'b0;
    logic        rst, frame_tick, kill_valid;
    logic [22:0] newCh;
    logic [2:0]  kill_idx, rd_idx;
    logic [22:0] rd_entry, rd_entry2;
    logic [7:0]  active_mask, active_mask2;
    logic        busy, busy2, miss_pulse, miss_pulse2;
    logic [7:0]  miss_count, miss_count2, drop_count, drop_count2;

    always #10 clk = ~clk;

    char_pool #(.SLOTS(8), .SCREEN_H(480), .SPAWN_DIV(1)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .newCh(newCh),
        .kill_valid(kill_valid), .kill_idx(kill_idx), .rd_idx(rd_idx),
        .rd_entry(rd_entry), .active_mask(active_mask), .busy(busy),
        .miss_pulse(miss_pulse), .miss_count(miss_count), .drop_count(drop_count));

    char_pool #(.SLOTS(8), .SCREEN_H(480), .SPAWN_DIV(3)) dut_div3 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .newCh(newCh),
        .kill_valid(kill_valid), .kill_idx(kill_idx), .rd_idx(rd_idx),
        .rd_entry(rd_entry2), .active_mask(active_mask2), .busy(busy2),
        .miss_pulse(miss_pulse2), .miss_count(miss_count2), .drop_count(drop_count2));

    typedef struct {
        logic [7:0] mask;
        int         pulses;
        logic [7:0] miss;
        logic [7:0] drop;
    } exp_t;

    exp_t        sb[$];
    bit          m_act [8];
    logic [22:0] m_ent [8];
    int          m_miss, m_drop;
    int          vectors = 0;
    int          miscompares = 0;
    logic [22:0] rv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_x(input logic [9:0] x);
`ifdef CHAR_POOL_CLAMP_X_EN
        return (x >= 10'd640) ? 10'd639 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < 8; i++) m[i] = m_act[i];
        return m;
    endfunction

    function automatic logic [22:0] rand_ch();
        return 23'($urandom);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_act[i] = 1'b0;
            m_ent[i] = 23'd0;
        end
        m_miss = 0;
        m_drop = 0;
        sb.delete();
    endtask

    task automatic read_slot(input int i, output logic [22:0] v);
        rd_idx = 3'(i);
        #1;
        v = rd_entry;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset(input string tag);
        logic [22:0] v;
        check({tag, "_mask"}, active_mask, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_miss_pulse"}, miss_pulse, 0);
        check({tag, "_miss_count"}, miss_count, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, v);
            check({tag, "_entry"}, v, 0);
        end
        @(negedge clk);
    endtask

    // kph: 0 no kill, 1 kill before the frame, 2 kill on the MOVE visit of ks, 3 kill during SPAWN
    task automatic run_frame(input logic [22:0] ch, input int kph, input int ks, input bit xtick);
        exp_t        e;
        int          pulses_exp, pulses, f, sum;
        logic [3:0]  spd;
        logic [22:0] v;
        pulses_exp = 0;
        f = -1;
        if (kph == 1) m_act[ks] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_act[i]) begin
                if (kph == 2 && i == ks) begin
                    m_act[i] = 1'b0;
                end else begin
                    spd = m_ent[i][22:19];
                    sum = int'(m_ent[i][18:10]) + ((spd == 4'd0) ? 1 : int'(spd));
                    if (sum >= 480) begin
                        m_act[i] = 1'b0;
                        pulses_exp++;
                        if (m_miss < 255) m_miss++;
                    end else begin
                        m_ent[i][18:10] = 9'(sum);
                    end
                end
            end
        end
        for (int i = 7; i >= 0; i--) if (!m_act[i]) f = i;
        if (kph == 3) m_act[ks] = 1'b0;
        if (f >= 0) begin
            m_act[f] = 1'b1;
            m_ent[f] = {ch[22:19], 9'd0, exp_x(ch[9:0])};
        end else if (m_drop < 255) begin
            m_drop++;
        end
        e.mask = m_mask();
        e.pulses = pulses_exp;
        e.miss = 8'(m_miss);
        e.drop = 8'(m_drop);
        sb.push_back(e);

        @(negedge clk);
        if (kph == 1) begin
            kill_valid = 1'b1;
            kill_idx = 3'(ks);
            @(negedge clk);
            kill_valid = 1'b0;
        end
        newCh = rand_ch();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        pulses = 0;
        for (int n = 0; n <= 8; n++) begin
            check("busy_run", busy, 1);
            if (miss_pulse) pulses++;
            newCh = (n == 8) ? ch : rand_ch();
            kill_valid = (kph == 2 && n == ks) || (kph == 3 && n == 8);
            kill_idx = 3'(ks);
            frame_tick = xtick && (n == 2 || n == 8);
            @(negedge clk);
        end
        kill_valid = 1'b0;
        frame_tick = 1'b0;
        newCh = rand_ch();
        if (miss_pulse) pulses++;
        check("busy_end", busy, 0);

        e = sb.pop_front();
        check("frame_mask", active_mask, e.mask);
        check("miss_pulses", pulses, e.pulses);
        check("miss_count", miss_count, e.miss);
        check("drop_count", drop_count, e.drop);
        for (int i = 0; i < 8; i++) begin
            if (m_act[i]) begin
                read_slot(i, v);
                check("entry", v, m_ent[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        kill_valid = 1'b0;
        newCh = 23'd0;
        kill_idx = 3'd0;
        rd_idx = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset("reset");
        check("div3_reset", active_mask2, 0);

        // First spawn, extra ticks during MOVE/SPAWN, horizontal clamp, frame divider
        run_frame({4'd5, 9'd0, 10'd100}, 0, 0, 1'b0);
        check("first_mask", active_mask, 8'h01);
        read_slot(0, rv);
        check("first_entry", rv, {4'd5, 9'd0, 10'd100});
        check("div3_f1", active_mask2, 0);
        run_frame({4'd3, 9'd0, 10'd700}, 0, 0, 1'b1);
        read_slot(0, rv);
        check("single_move", rv[18:10], 9'd5);
        read_slot(1, rv);
`ifdef CHAR_POOL_CLAMP_X_EN
        check("spawn_x", rv[9:0], 10'd639);
`else
        check("spawn_x", rv[9:0], 10'd700);
`endif
        check("div3_f2", active_mask2, 0);
        run_frame({4'd2, 9'd0, 10'd5}, 0, 0, 1'b0);
        check("div3_f3", active_mask2, 8'h01);

        // Speed 0 moves by one; speed 15 leaves the screen; kill on visit suppresses a miss
        do_reset();
        run_frame({4'd0, 9'd0, 10'd50}, 0, 0, 1'b0);
        repeat (10) run_frame(rand_ch(), 1, 1, 1'b0);
        read_slot(0, rv);
        check("slow_v10", rv[18:10], 9'd10);
        run_frame(rand_ch(), 1, 1, 1'b0);
        read_slot(0, rv);
        check("slow_v11", rv[18:10], 9'd11);
        run_frame({4'd15, 9'd0, 10'd200}, 1, 1, 1'b0);
        repeat (32) run_frame(rand_ch(), 1, 2, 1'b0);
        check("fast_miss", miss_count, 8'd1);
        run_frame({4'd9, 9'd0, 10'd300}, 1, 1, 1'b0);
        repeat (53) run_frame(rand_ch(), 1, 2, 1'b0);
        read_slot(1, rv);
        check("v477", rv[18:10], 9'd477);
        run_frame(rand_ch(), 2, 1, 1'b0);
        check("kill_no_miss", miss_count, 8'd1);

        repeat (60) run_frame(rand_ch(), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1)));

        // Full pool: drops count up and saturate
        do_reset();
        repeat (8) run_frame({4'd0, 9'd0, 10'($urandom_range(0, 1023))}, 0, 0, 1'b0);
        run_frame(rand_ch(), 0, 0, 1'b0);
        check("full_mask", active_mask, 8'hFF);
        check("first_drop", drop_count, 8'd1);
        repeat (299) run_frame(rand_ch(), 0, 0, 1'b0);
        check("drop_sat", drop_count, 8'd255);

        // Reset in the 4th MOVE cycle aborts the sequence
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset("abort");
        run_frame({4'd1, 9'd0, 10'd10}, 0, 0, 1'b0);
        check("after_abort", active_mask, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
